// File: rtl/lorenz_step_sequencer.sv
// One forward-Euler step of the Lorenz system per start request.
// A single shared signed 7.20 multiplier is time-multiplexed over seven product states.
module lorenz_step_sequencer #(
  parameter int WIDTH   = 27,
  parameter int FRAC    = 20,
  parameter int X_RESET = -1048576,
  parameter int Y_RESET = 104858,
  parameter int Z_RESET = 26214400
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    init_load,
  input  logic signed [WIDTH-1:0] x_init,
  input  logic signed [WIDTH-1:0] y_init,
  input  logic signed [WIDTH-1:0] z_init,
  input  logic signed [WIDTH-1:0] sigma,
  input  logic signed [WIDTH-1:0] rho,
  input  logic signed [WIDTH-1:0] beta,
  input  logic signed [WIDTH-1:0] dt,
  output logic                    busy,
  output logic                    step_done,
  output logic signed [WIDTH-1:0] x,
  output logic signed [WIDTH-1:0] y,
  output logic signed [WIDTH-1:0] z,
  output logic [31:0]             step_count
);

  localparam logic signed [WIDTH-1:0] X_RST = WIDTH'(X_RESET);
  localparam logic signed [WIDTH-1:0] Y_RST = WIDTH'(Y_RESET);
  localparam logic signed [WIDTH-1:0] Z_RST = WIDTH'(Z_RESET);

  typedef enum logic [3:0] {
    IDLE, MUL0, MUL1, MUL2, MUL3, MUL4, MUL5, MUL6, UPD
  } state_t;

  state_t state, next_state;

  logic signed [WIDTH-1:0] sigma_q, rho_q, beta_q, dt_q;
  logic signed [WIDTH-1:0] dx, t1, t2, t3, ix, iy, iz;
  logic signed [WIDTH-1:0] op_a, op_b, prod_q;
  logic [2*WIDTH-1:0]      prod_full;
  logic                    accept;
  logic                    unused_prod_bits;

  assign accept = (state == IDLE) && start && !init_load;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // init_load cancels any step in flight and parks the sequencer in IDLE
  always_comb begin
    next_state = state;
    if (init_load) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) next_state = MUL0;
        MUL0:    next_state = MUL1;
        MUL1:    next_state = MUL2;
        MUL2:    next_state = MUL3;
        MUL3:    next_state = MUL4;
        MUL4:    next_state = MUL5;
        MUL5:    next_state = MUL6;
        MUL6:    next_state = UPD;
        UPD:     next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      MUL0: begin op_a = sigma_q;  op_b = y - x;     end
      MUL1: begin op_a = x;        op_b = rho_q - z; end
      MUL2: begin op_a = x;        op_b = y;         end
      MUL3: begin op_a = beta_q;   op_b = z;         end
      MUL4: begin op_a = dx;       op_b = dt_q;      end
      MUL5: begin op_a = t1 - y;   op_b = dt_q;      end
      MUL6: begin op_a = t2 - t3;  op_b = dt_q;      end
      default: ;
    endcase
  end

  // Floor shift by FRAC keeping the true product sign; the dropped bits wrap silently
  assign prod_full = {{WIDTH{op_a[WIDTH-1]}}, op_a} * {{WIDTH{op_b[WIDTH-1]}}, op_b};
  assign prod_q    = {prod_full[2*WIDTH-1], prod_full[WIDTH+FRAC-2:FRAC]};
  assign unused_prod_bits = ^{prod_full[2*WIDTH-2:WIDTH+FRAC-1], prod_full[FRAC-1:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      x          <= X_RST;
      y          <= Y_RST;
      z          <= Z_RST;
      step_count <= '0;
      step_done  <= 1'b0;
      sigma_q    <= '0;
      rho_q      <= '0;
      beta_q     <= '0;
      dt_q       <= '0;
      dx         <= '0;
      t1         <= '0;
      t2         <= '0;
      t3         <= '0;
      ix         <= '0;
      iy         <= '0;
      iz         <= '0;
    end else begin
      step_done <= 1'b0;
      if (init_load) begin
        x          <= x_init;
        y          <= y_init;
        z          <= z_init;
        step_count <= '0;
      end else begin
        if (accept) begin
          sigma_q <= sigma;
          rho_q   <= rho;
          beta_q  <= beta;
          dt_q    <= dt;
        end
        case (state)
          MUL0: dx <= prod_q;
          MUL1: t1 <= prod_q;
          MUL2: t2 <= prod_q;
          MUL3: t3 <= prod_q;
          MUL4: ix <= prod_q;
          MUL5: iy <= prod_q;
          MUL6: iz <= prod_q;
          UPD: begin
            x          <= x + ix;
            y          <= y + iy;
            z          <= z + iz;
            step_count <= step_count + 32'd1;
            step_done  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lorenz_step_sequencer.sv
// Bench for lorenz_step_sequencer: directed handshake cases plus randomized steps
// checked against an arithmetic Euler-step model.
module tb_lorenz_step_sequencer;

  localparam int W = 27;

  logic clock = 1'b0;
  logic reset, start, init_load;
  logic signed [W-1:0] x_init, y_init, z_init, sigma, rho, beta, dt;
  logic busy, step_done;
  logic signed [W-1:0] x, y, z;
  logic [31:0] step_count;

  int compared = 0;
  int mismatched = 0;

  logic signed [W-1:0] mx, my, mz;
  logic [31:0] mcnt;
  logic signed [W-1:0] cs, cr, cb, cd;
  int hi, earlyDone, dones, bad;
  bit seen;

  lorenz_step_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .init_load(init_load),
    .x_init(x_init), .y_init(y_init), .z_init(z_init),
    .sigma(sigma), .rho(rho), .beta(beta), .dt(dt),
    .busy(busy), .step_done(step_done),
    .x(x), .y(y), .z(z), .step_count(step_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic il);
    start     = st;
    init_load = il;
  endtask

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Signed 7.20 product: floor(a*b / 2^20), true sign kept in the top bit, low 26 bits wrap
  function automatic logic signed [W-1:0] refMul(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
    longint prod, q;
    prod = longint'(a) * longint'(b);
    q    = prod >>> 20;
    return {(prod < 0), q[W-2:0]};
  endfunction

  task automatic modelStep(input logic signed [W-1:0] s, input logic signed [W-1:0] r,
                           input logic signed [W-1:0] b, input logic signed [W-1:0] d);
    logic signed [W-1:0] fx, fy, fz, xy, bz, diff1, diff2;
    fx    = refMul(s, my - mx);
    fy    = refMul(mx, r - mz);
    xy    = refMul(mx, my);
    bz    = refMul(b, mz);
    diff1 = fy - my;
    diff2 = xy - bz;
    mx    = mx + refMul(fx, d);
    my    = my + refMul(diff1, d);
    mz    = mz + refMul(diff2, d);
    mcnt  = mcnt + 32'd1;
  endtask

  task automatic modelLoad(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                           input logic signed [W-1:0] c);
    mx = a; my = b; mz = c; mcnt = '0;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    x_init = '0; y_init = '0; z_init = '0;
    sigma = '0; rho = '0; beta = '0; dt = '0;
    tick();
    tick();
    checkOutput("rst_x", x, -1048576);
    checkOutput("rst_y", y, 104858);
    checkOutput("rst_z", z, 26214400);
    checkOutput("rst_cnt", step_count, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", step_done, 0);
    reset = 1'b0;
    modelLoad(W'(-1048576), W'(104858), W'(26214400));

    // Step from reset state: beta*z overflows the 7.20 range
    sigma = W'(10485760); rho = W'(29360128); beta = W'(2796203); dt = W'(4096);
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (step_done) seen = 1;
    end
    checkOutput("wrap_done", seen, 1);
    modelStep(sigma, rho, beta, dt);
    checkOutput("wrap_x", x, mx);
    checkOutput("wrap_y", y, my);
    checkOutput("wrap_z", z, mz);

    // Single step from x=y=z=1.0
    x_init = W'(1048576); y_init = W'(1048576); z_init = W'(1048576);
    applyStimulus(1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0);
    modelLoad(x_init, y_init, z_init);
    checkOutput("load_x", x, 1048576);
    checkOutput("load_z", z, 1048576);
    checkOutput("load_cnt", step_count, 0);
    checkOutput("load_done", step_done, 0);
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    hi = 0; earlyDone = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) hi++;
      if (step_done) earlyDone++;
      tick();
    end
    checkOutput("single_busy_cycles", hi, 8);
    checkOutput("single_early_done", earlyDone, 0);
    checkOutput("single_done", step_done, 1);
    checkOutput("single_busy_low", busy, 0);
    checkOutput("single_x", x, 1048576);
    checkOutput("single_y", y, 1155072);
    checkOutput("single_z", z, 1041749);
    checkOutput("single_cnt", step_count, 1);
    modelStep(sigma, rho, beta, dt);
    checkOutput("single_model_z", z, mz);
    tick();
    checkOutput("single_done_pulse", step_done, 0);

    // Start while busy is dropped and constants are frozen at accept
    applyStimulus(1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    tick();
    sigma = '0;
    tick();
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("latch_done", step_done, 1);
    checkOutput("latch_x", x, 1048576);
    checkOutput("latch_y", y, 1155072);
    checkOutput("latch_z", z, 1041749);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (step_done) dones++;
    end
    checkOutput("latch_extra_done", dones, 0);
    checkOutput("latch_cnt", step_count, 1);
    sigma = W'(10485760);

    // Back-to-back with start held high
    applyStimulus(1'b0, 1'b1);
    tick();
    modelLoad(x_init, y_init, z_init);
    applyStimulus(1'b1, 1'b0);
    dones = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (step_done) dones++;
      if (busy == step_done) bad++;
    end
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 20 && busy; i++) begin
      tick();
      if (step_done) dones++;
    end
    for (int i = 0; i < 5; i++) modelStep(sigma, rho, beta, dt);
    checkOutput("b2b_dones", dones, 5);
    checkOutput("b2b_busy_vs_done", bad, 0);
    checkOutput("b2b_cnt", step_count, 5);
    checkOutput("b2b_x", x, mx);
    checkOutput("b2b_y", y, my);
    checkOutput("b2b_z", z, mz);

    // Abort mid-step with init_load
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    tick(); tick(); tick();
    x_init = W'(2097152);
    applyStimulus(1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0);
    modelLoad(x_init, y_init, z_init);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", step_done, 0);
    checkOutput("abort_x", x, 2097152);
    checkOutput("abort_y", y, 1048576);
    checkOutput("abort_cnt", step_count, 0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (step_done) dones++;
    end
    checkOutput("abort_no_done", dones, 0);
    checkOutput("abort_x_hold", x, 2097152);

    // Randomized steps; constants are scrambled right after accept
    for (int iter = 0; iter < 24; iter++) begin
      if (iter % 4 == 0) begin
        x_init = W'($urandom); y_init = W'($urandom); z_init = W'($urandom);
        applyStimulus(1'b0, 1'b1);
        tick();
        modelLoad(x_init, y_init, z_init);
      end
      cs = W'($urandom); cr = W'($urandom); cb = W'($urandom); cd = W'($urandom_range(0, 65535));
      sigma = cs; rho = cr; beta = cb; dt = cd;
      applyStimulus(1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0);
      sigma = W'($urandom); rho = W'($urandom); beta = W'($urandom); dt = W'($urandom);
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        tick();
        if (step_done) seen = 1;
      end
      checkOutput("rnd_done", seen, 1);
      modelStep(cs, cr, cb, cd);
      checkOutput("rnd_x", x, mx);
      checkOutput("rnd_y", y, my);
      checkOutput("rnd_z", z, mz);
      checkOutput("rnd_cnt", step_count, mcnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
